// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, RV32I size
// encodings and the access legality check used when an op is accepted.
package lsu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic opLegal(input logic [2:0] funct3, input logic [1:0] addrLo,
                                   input logic isStore);
    logic ok;
    case (funct3)
      LB:      ok = 1'b1;
      LH:      ok = ~addrLo[0];
      LW:      ok = (addrLo == 2'b00);
      LBU:     ok = ~isStore;
      LHU:     ok = ~isStore & ~addrLo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: byte enables, store lane
// replication and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

  // funct3[1:0] selects the size, funct3[2] selects zero-extension.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = w_shifted;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'h0, w_shifted[7:0]}
                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'h0, w_shifted[15:0]}
                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = w_shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a
// request/ack memory port, with alignment checks and an ack timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] LastCount = 32'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic [31:0] r_count;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_idle;
  logic        w_inReq;
  logic        w_oneDir;
  logic        w_legal;
  logic        w_accept;
  logic        w_reject;
  logic [3:0]  w_be;
  logic [31:0] w_laneData;
  logic [31:0] w_loadData;

  assign w_idle   = (r_state == S_IDLE);
  assign w_inReq  = (r_state == S_REQ);
  assign w_oneDir = memread_i ^ memwrite_i;
  assign w_legal  = opLegal(funct3_i, addr_i[1:0], memwrite_i);
  assign w_accept = w_idle & valid_i & w_oneDir & w_legal;
  assign w_reject = w_idle & valid_i & ((memread_i & memwrite_i) | (w_oneDir & ~w_legal));

  lsu_align u_align (
    .funct3_i  (r_funct3),
    .addr_lo_i (r_addr[1:0]),
    .wdata_i   (r_wdata),
    .rdata_i   (mem_rdata_i),
    .be_o      (w_be),
    .wdata_o   (w_laneData),
    .rdata_o   (w_loadData)
  );

  // Memory-side outputs are driven only while a request is outstanding.
  assign stall_o     = w_accept | w_inReq;
  assign done_o      = (r_state == S_RESP);
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = w_inReq;
  assign mem_we_o    = w_inReq & r_write;
  assign mem_addr_o  = w_inReq ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_be_o    = w_inReq ? w_be : 4'h0;
  assign mem_wdata_o = (w_inReq & r_write) ? w_laneData : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_write  <= 1'b0;
      r_count  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_err <= w_reject;
          if (w_accept) begin
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            r_funct3 <= funct3_i;
            r_write  <= memwrite_i;
            r_count  <= 32'h0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (mem_ack_i) begin
            if (!r_write) r_rdata <= w_loadData;
            r_count <= 32'h0;
            r_state <= S_RESP;
          end else if (r_count == LastCount) begin
            r_count <= 32'h0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + 32'h1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores against an arithmetic reference model of the lane rules.
module tb_load_store_unit;

  localparam int TimeoutCycles = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [2:0]  funct3_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(TimeoutCycles)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .funct3_i(funct3_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: access size in bytes from funct3, -1 when illegal.
  function automatic int refSize(input logic [2:0] f3, input logic isStore);
    case (f3)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return isStore ? -1 : 1;
      3'b101: return isStore ? -1 : 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic refLegal(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic isStore);
    int size = refSize(f3, isStore);
    if (size < 0) return 1'b0;
    return (addr % size) == 0;
  endfunction

  function automatic logic [3:0] refBe(input logic [2:0] f3, input logic [31:0] addr);
    int size = refSize(f3, 1'b0);
    int off = addr % 4;
    int mask = (1 << size) - 1;
    return 4'(mask << off);
  endfunction

  function automatic logic [31:0] refStore(input logic [2:0] f3, input logic [31:0] d);
    int size = refSize(f3, 1'b1);
    if (size == 1) return (d % 256) * 32'h01010101;
    if (size == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] mem);
    int size = refSize(f3, 1'b0);
    logic [31:0] v = mem / (32'h1 << (8 * (addr % 4)));
    if (size == 1) begin
      v = v % 256;
      if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2) begin
      v = v % 65536;
      if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d);
    valid_i    = v;
    memread_i  = rd;
    memwrite_i = wr;
    funct3_i   = f3;
    addr_i     = a;
    wdata_i    = d;
  endtask

  // Full legal transaction; waitCycles extra REQ cycles before the ack.
  task automatic runOp(input logic isStore, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] mem, input int waitCycles);
    applyStimulus(1'b1, ~isStore, isStore, f3, a, d);
    #1;
    checkOutput("acceptStall", 32'(stall_o), 32'd1);
    checkOutput("acceptNoReq", 32'(mem_req_o), 32'd0);
    for (int i = 0; i <= waitCycles; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'hFFFF_FFF0, 32'h1234_5678);
      mem_ack_i   = (i == waitCycles);
      mem_rdata_i = (i == waitCycles) ? mem : 32'h5A5A_5A5A;
      #1;
      checkOutput("reqReq", 32'(mem_req_o), 32'd1);
      checkOutput("reqStall", 32'(stall_o), 32'd1);
      checkOutput("reqAddr", mem_addr_o, a & 32'hFFFF_FFFC);
      checkOutput("reqBe", 32'(mem_be_o), 32'(refBe(f3, a)));
      checkOutput("reqWe", 32'(mem_we_o), 32'(isStore));
      if (isStore) checkOutput("reqWdata", mem_wdata_o, refStore(f3, d));
    end
    nextCycle();
    mem_ack_i = 1'b1;
    #1;
    checkOutput("respDone", 32'(done_o), 32'd1);
    checkOutput("respStall", 32'(stall_o), 32'd0);
    checkOutput("respErr", 32'(err_o), 32'd0);
    checkOutput("respReq", 32'(mem_req_o), 32'd0);
    if (!isStore) checkOutput("respRdata", rdata_o, refLoad(f3, a, mem));
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_ack_i = 1'b0;
    #1;
    checkOutput("donePulse", 32'(done_o), 32'd0);
    checkOutput("idleReq", 32'(mem_req_o), 32'd0);
  endtask

  task automatic runBadOp(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a);
    applyStimulus(1'b1, rd, wr, f3, a, 32'hCAFE_F00D);
    #1;
    checkOutput("badNoReq0", 32'(mem_req_o), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("badErr", 32'(err_o), 32'd1);
    checkOutput("badNoReq1", 32'(mem_req_o), 32'd0);
    checkOutput("badNoDone", 32'(done_o), 32'd0);
    nextCycle();
    checkOutput("badErrPulse", 32'(err_o), 32'd0);
    checkOutput("badNoReq2", 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        st;
    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    checkOutput("rstStall", 32'(stall_o), 32'd0);
    checkOutput("rstDone", 32'(done_o), 32'd0);
    checkOutput("rstErr", 32'(err_o), 32'd0);
    checkOutput("rstRdata", rdata_o, 32'h0);
    checkOutput("rstBe", 32'(mem_be_o), 32'h0);
    checkOutput("rstReq", 32'(mem_req_o), 32'd0);
    rst_i = 1'b0;
    nextCycle();

    $display("[TB] directed cases");
    runOp(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    runOp(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    runOp(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    runOp(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0);
    runOp(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 2);
    runOp(1'b0, 3'b010, 32'h300, 32'h0, 32'h1357_9BDF, TimeoutCycles - 1);
    runBadOp(1'b1, 1'b0, 3'b010, 32'h101);
    runBadOp(1'b1, 1'b0, 3'b001, 32'h101);
    runBadOp(1'b1, 1'b1, 3'b010, 32'h100);
    runBadOp(1'b0, 1'b1, 3'b100, 32'h100);
    runBadOp(1'b1, 1'b0, 3'b011, 32'h100);

    $display("[TB] timeout case");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    for (int i = 0; i < TimeoutCycles; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      #1;
      checkOutput("toReq", 32'(mem_req_o), 32'd1);
      checkOutput("toNoErr", 32'(err_o), 32'd0);
    end
    nextCycle();
    checkOutput("toReqDrop", 32'(mem_req_o), 32'd0);
    checkOutput("toErr", 32'(err_o), 32'd1);
    checkOutput("toNoDone", 32'(done_o), 32'd0);
    nextCycle();
    checkOutput("toErrPulse", 32'(err_o), 32'd0);
    checkOutput("toIdle", 32'(stall_o), 32'd0);

    $display("[TB] reset during request");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkOutput("midReq", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("asyncReq", 32'(mem_req_o), 32'd0);
    checkOutput("asyncBe", 32'(mem_be_o), 32'h0);
    checkOutput("asyncAddr", mem_addr_o, 32'h0);
    checkOutput("asyncRdata", rdata_o, 32'h0);
    checkOutput("asyncStall", 32'(stall_o), 32'd0);
    nextCycle();
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    nextCycle();
    mem_ack_i = 1'b0;
    #1;
    checkOutput("lateAckDone", 32'(done_o), 32'd0);
    checkOutput("lateAckRdata", rdata_o, 32'h0);
    checkOutput("lateAckReq", 32'(mem_req_o), 32'd0);
    nextCycle();
    checkOutput("lateAckDone2", 32'(done_o), 32'd0);

    $display("[TB] randomized cases");
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (refLegal(f3, a, st) && ($urandom_range(0, 3) != 0 || n < 40))
        runOp(st, f3, a, $urandom, $urandom, $urandom_range(0, TimeoutCycles - 1));
      else if (!refLegal(f3, a, st))
        runBadOp(~st, st, f3, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
